// File: rtl/y86_pkg.sv
// y86_pkg
// Shared Y86-64 constants for the condition-code logic: jXX/cmovXX function
// codes, bit positions of the flags inside the packed {ZF,SF,OF} vector, and
// the state type of the condition-code unit FSM.
package y86_pkg;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } cc_state_t;

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// cond_eval
// Purely combinational jXX/cmovXX condition evaluator. Shared with the SEQ
// datapath, so it carries no state and no clock.
//   cc   in  3  flags {ZF,SF,OF}
//   ifun in  4  Y86 function code
//   cnd  out 1  condition result (0 for undefined codes)
//   bad  out 1  ifun is not a defined condition (> 6)
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       bad
);

  logic zf;
  logic lt;

  assign zf = cc[CC_ZF];
  // Signed less-than after a subtract: sign differs from overflow.
  assign lt = cc[CC_SF] ^ cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    bad = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit
// Execute-stage condition-code register and registered condition result.
// Latches ALU flags on OPq instructions and evaluates jXX/cmovXX against the
// committed flags.
//
// state  | meaning
// RUN    | normal operation: flag updates and condition evaluation
// HALTED | processor halted; outputs frozen, out_valid low, until rst_n
//
//   clk, rst_n        clock, async active-low reset
//   in_valid          instruction present in execute
//   set_cc, cc_in     OPq flag update request and ALU flags {ZF,SF,OF}
//   is_cond, ifun     jXX/cmovXX request and function code
//   stall             hold all state
//   exc_in            downstream exception: drop this cycle's flag update
//   halt              freeze the unit
//   cc_out            committed flags
//   out_valid, cnd, bad_ifun   registered condition result
module cc_cond_unit
  import y86_pkg::*;
#(
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       set_cc,
  input  logic [2:0] cc_in,
  input  logic       is_cond,
  input  logic [3:0] ifun,
  input  logic       stall,
  input  logic       exc_in,
  input  logic       halt,
  output logic [2:0] cc_out,
  output logic       out_valid,
  output logic       cnd,
  output logic       bad_ifun
);

  cc_state_t  state_q;
  logic [2:0] cc_q;
  logic       out_valid_q;
  logic       cnd_q;
  logic       bad_q;

  logic       eval_cnd;
  logic       eval_bad;

  // Evaluated against the committed flags, so an OPq followed directly by a
  // jXX sees the OPq's flags without any bypass.
  cond_eval u_cond_eval (
    .cc   (cc_q),
    .ifun (ifun),
    .cnd  (eval_cnd),
    .bad  (eval_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cc_q        <= CC_RESET;
      out_valid_q <= 1'b0;
      cnd_q       <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt) begin
            // Halt wins over stall and drops any concurrent flag update.
            state_q     <= HALTED;
            out_valid_q <= 1'b0;
          end else if (!stall) begin
            if (in_valid && set_cc && !exc_in) begin
              cc_q <= cc_in;
            end
            out_valid_q <= in_valid;
            if (in_valid) begin
              cnd_q <= is_cond & eval_cnd;
              bad_q <= is_cond & eval_bad;
            end
          end
        end
        HALTED: begin
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= RUN;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cc_out    = cc_q;
  assign out_valid = out_valid_q;
  assign cnd       = cnd_q;
  assign bad_ifun  = bad_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
module tb_cc_cond_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       set_cc;
  logic [2:0] cc_in;
  logic       is_cond;
  logic [3:0] ifun;
  logic       stall;
  logic       exc_in;
  logic       halt;
  logic [2:0] cc_out;
  logic       out_valid;
  logic       cnd;
  logic       bad_ifun;

  int n_chk;
  int n_err;

  // Reference model state
  int  m_cc;
  bit  m_ov;
  bit  m_cnd;
  bit  m_bad;
  bit  m_halted;

  cc_cond_unit #(.CC_RESET(3'b100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .set_cc    (set_cc),
    .cc_in     (cc_in),
    .is_cond   (is_cond),
    .ifun      (ifun),
    .stall     (stall),
    .exc_in    (exc_in),
    .halt      (halt),
    .cc_out    (cc_out),
    .out_valid (out_valid),
    .cnd       (cnd),
    .bad_ifun  (bad_ifun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Condition table with flags as integers: ZF=4, SF=2, OF=1 weights.
  function automatic bit ref_cond(input int flags, input int fn);
    bit zf, lt;
    zf = (flags / 4) % 2 == 1;
    lt = ((flags / 2) % 2) != (flags % 2);
    case (fn)
      0: return 1'b1;
      1: return lt || zf;
      2: return lt;
      3: return zf;
      4: return !zf;
      5: return !lt;
      6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".cc"},  {5'd0, cc_out}, m_cc[7:0]);
    chk({tag, ".ov"},  {7'd0, out_valid}, {7'd0, m_ov});
    chk({tag, ".cnd"}, {7'd0, cnd}, {7'd0, m_cnd});
    chk({tag, ".bad"}, {7'd0, bad_ifun}, {7'd0, m_bad});
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    m_cc = 4; m_ov = 0; m_cnd = 0; m_bad = 0; m_halted = 0;
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input string tag, input bit iv, input bit sc, input int ccv,
                      input bit ic, input int fn, input bit st, input bit ex, input bit hl);
    bit r;
    in_valid = iv; set_cc = sc; cc_in = ccv[2:0]; is_cond = ic;
    ifun = fn[3:0]; stall = st; exc_in = ex; halt = hl;
    @(posedge clk);
    if (m_halted) begin
      m_ov = 0;
    end else if (hl) begin
      m_halted = 1;
      m_ov = 0;
    end else if (!st) begin
      r = ref_cond(m_cc, fn);
      if (iv && sc && !ex) m_cc = ccv;
      m_ov = iv;
      if (iv) begin
        m_cnd = ic && r;
        m_bad = ic && (fn > 6);
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic opq(input string tag, input int ccv);
    step(tag, 1, 1, ccv, 0, 0, 0, 0, 0);
  endtask

  task automatic jxx(input string tag, input int fn);
    step(tag, 1, 0, 0, 1, fn, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    in_valid = 0; set_cc = 0; cc_in = 0; is_cond = 0; ifun = 0;
    stall = 0; exc_in = 0; halt = 0;
    rst_n = 1'b1;
    #1;
    do_reset("reset");
    chk("reset.cc_lit", {5'd0, cc_out}, 8'h04);

    // First instruction after reset: je against reset flags (ZF=1)
    jxx("first_je", 3);
    chk("first_je.lit", {7'd0, cnd}, 8'h01);

    // OPq then jl back-to-back
    opq("opq011", 3'b011);
    jxx("jl_after011", 2);
    chk("jl_after011.lit", {7'd0, cnd}, 8'h00);
    opq("opq010", 3'b010);
    jxx("jl_after010", 2);
    chk("jl_after010.lit", {7'd0, cnd}, 8'h01);

    // Full sweep of flags x defined ifuns, plus an undefined code
    for (int f = 0; f < 8; f++) begin
      opq("sweep_opq", f);
      for (int fn = 0; fn < 7; fn++) jxx("sweep_j", fn);
      jxx("sweep_bad", 9);
    end
    chk("bad9.lit", {6'd0, cnd, bad_ifun}, 8'h01);

    // Non-conditional instruction clears cnd/bad; idle cycle holds them
    jxx("pre_hold", 0);
    step("idle_hold", 0, 0, 0, 1, 9, 0, 0, 0);
    step("noncond", 1, 0, 0, 0, 9, 0, 0, 0);

    // Exception suppresses flag update only
    do_reset("reset2");
    step("exc_opq", 1, 1, 3'b000, 0, 0, 0, 1, 0);
    chk("exc_opq.lit", {5'd0, cc_out}, 8'h04);
    jxx("exc_jne", 4);
    chk("exc_jne.lit", {7'd0, cnd}, 8'h00);

    // Stall holds everything
    opq("pre_stall", 3'b001);
    jxx("pre_stall_j", 2);
    step("stall1", 1, 1, 3'b100, 0, 0, 1, 0, 0);
    step("stall2", 1, 0, 0, 1, 4, 1, 0, 0);
    step("stall3", 1, 0, 0, 1, 9, 1, 0, 0);
    opq("post_stall", 3'b110);
    chk("post_stall.lit", {5'd0, cc_out}, 8'h06);
    jxx("post_stall_j", 1);

    // set_cc together with is_cond: both happen, cnd uses old flags
    step("both", 1, 1, 3'b000, 1, 3, 0, 0, 0);

    // Halt, with a concurrent OPq that must be dropped
    jxx("pre_halt", 0);
    step("halt", 1, 1, 3'b010, 0, 0, 1, 0, 1);
    chk("halt.ov_lit", {7'd0, out_valid}, 8'h00);
    opq("halted_opq", 3'b000);
    jxx("halted_j", 4);
    do_reset("reset_halt");
    chk("reset_halt.cc_lit", {5'd0, cc_out}, 8'h04);
    jxx("after_halt_j", 3);

    // Reset in mid-stall
    opq("rs_opq", 3'b011);
    step("rs_stall", 1, 1, 3'b001, 0, 0, 1, 0, 0);
    stall = 1;
    do_reset("reset_stall");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int fn;
      fn = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 15) : $urandom_range(0, 6);
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_reset");
      end else begin
        step("rnd",
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 7),
             $urandom_range(0, 1) == 1,
             fn,
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 149) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
